// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Shared types and constants for the change dispenser. Holds
//               the dispenser FSM state enum, the one-hot coin selectors,
//               their unit values, the tube reset fill level and small
//               helpers for one-hot checks and coin value lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // One-hot coin / tube selectors
    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_2  = 4'b0010;
    localparam logic [3:0] COIN_5  = 4'b0100;
    localparam logic [3:0] COIN_10 = 4'b1000;

    // Unit value of each coin
    localparam logic [3:0] COIN_1_VAL  = 4'd1;
    localparam logic [3:0] COIN_2_VAL  = 4'd2;
    localparam logic [3:0] COIN_5_VAL  = 4'd5;
    localparam logic [3:0] COIN_10_VAL = 4'd10;

    // Fill level of every tube after reset
    localparam logic [3:0] TUBE_RESET = 4'd5;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == COIN_1) || (v == COIN_2) || (v == COIN_5) || (v == COIN_10);
    endfunction

    // Non-one-hot selectors map to zero so a bad select never moves money
    function automatic logic [3:0] coin_value(input logic [3:0] sel);
        logic [3:0] val;
        val = 4'd0;
        case (sel)
            COIN_1:  val = COIN_1_VAL;
            COIN_2:  val = COIN_2_VAL;
            COIN_5:  val = COIN_5_VAL;
            COIN_10: val = COIN_10_VAL;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cd_tube_bank.sv
`default_nettype none
// ============================================================================
// Module      : cd_tube_bank
// Description : Four saturating 4-bit coin tube counters. Refill adds one
//               coin to the one-hot selected tube (saturating at 15,
//               non-one-hot selects ignored); dec_en removes one coin from
//               the tube chosen by dec_sel (floored at 0). Refill and
//               decrement on the same tube in one cycle cancel out.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               refill, refill_sel  - refill strobe and one-hot tube select
//               dec_en, dec_sel     - dispense strobe and one-hot tube select
//               tube_count          - {10, 5, 2, 1} counts, 4 bits each
// Revision    : 1.0 - initial release
// ============================================================================
module cd_tube_bank
    import vm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        refill,
    input  logic [3:0]  refill_sel,
    input  logic        dec_en,
    input  logic [3:0]  dec_sel,
    output logic [15:0] tube_count
);

    logic w_refill_ok;
    assign w_refill_ok = refill & is_onehot4(refill_sel);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_tube
            logic [3:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc = w_refill_ok & refill_sel[i];
            assign w_dec = dec_en & dec_sel[i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= TUBE_RESET;
                end else if (w_inc && !w_dec) begin
                    if (r_cnt != 4'd15) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end else if (w_dec && !w_inc) begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            end

            assign tube_count[i*4 +: 4] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_ctrl
// Description : Greedy change dispenser. Accepts a change amount in IDLE,
//               then repeatedly picks the largest coin not exceeding the
//               amount still owed whose tube is non-empty, ejects it with a
//               req/ack handshake, and finishes with a one-cycle done pulse.
//               If change cannot be completed, a sticky short_fault is set
//               and remaining holds the unpaid amount.
// Config      : CHANGE_ACK_TIMEOUT_EN - when defined, an 8-bit counter aborts
//               an ejection to FAULT after 255 cycles without eject_ack.
// Ports       : clk, reset                 - clock, sync active-high reset
//               change_valid/amount/ready  - change request handshake
//               eject_req/sel/ack          - coin ejector handshake
//               refill, refill_sel         - tube refill strobe / select
//               busy, done, short_fault    - status
//               remaining, tube_count      - amount owed, tube fill levels
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispense_ctrl
    import vm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        change_valid,
    input  logic [3:0]  change_amount,
    output logic        change_ready,
    output logic        eject_req,
    output logic [3:0]  eject_sel,
    input  logic        eject_ack,
    input  logic        refill,
    input  logic [3:0]  refill_sel,
    output logic        busy,
    output logic        done,
    output logic        short_fault,
    output logic [3:0]  remaining,
    output logic [15:0] tube_count
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_remaining;
    logic [3:0]  w_next_remaining;
    logic [3:0]  r_eject_sel;
    logic [3:0]  w_next_eject_sel;
    logic        r_short_fault;
    logic        w_next_short_fault;
    logic        w_dec_en;
    logic [3:0]  w_pick;
    logic [15:0] w_counts;
    logic        w_timeout;

    cd_tube_bank u_tube_bank (
        .clk        (clk),
        .reset      (reset),
        .refill     (refill),
        .refill_sel (refill_sel),
        .dec_en     (w_dec_en),
        .dec_sel    (r_eject_sel),
        .tube_count (w_counts)
    );

`ifdef CHANGE_ACK_TIMEOUT_EN
    // Counts EJECT cycles without an ack; the 255th such cycle aborts.
    logic [7:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != EJECT) || eject_ack) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == EJECT) && !eject_ack && (r_wait_cnt == 8'd254);
`else
    assign w_timeout = 1'b0;
`endif

    // Greedy picker, largest denomination first, using registered counts
    always_comb begin
        w_pick = 4'd0;
        if ((r_remaining >= COIN_10_VAL) && (w_counts[15:12] != 4'd0)) begin
            w_pick = COIN_10;
        end else if ((r_remaining >= COIN_5_VAL) && (w_counts[11:8] != 4'd0)) begin
            w_pick = COIN_5;
        end else if ((r_remaining >= COIN_2_VAL) && (w_counts[7:4] != 4'd0)) begin
            w_pick = COIN_2;
        end else if ((r_remaining >= COIN_1_VAL) && (w_counts[3:0] != 4'd0)) begin
            w_pick = COIN_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_remaining   <= 4'd0;
            r_eject_sel   <= 4'd0;
            r_short_fault <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_remaining   <= w_next_remaining;
            r_eject_sel   <= w_next_eject_sel;
            r_short_fault <= w_next_short_fault;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_remaining   = r_remaining;
        w_next_eject_sel   = r_eject_sel;
        w_next_short_fault = r_short_fault;
        w_dec_en           = 1'b0;

        case (r_state)
            IDLE: begin
                if (change_valid) begin
                    w_next_remaining   = change_amount;
                    w_next_short_fault = 1'b0;
                    w_next_state       = SELECT;
                end
            end
            SELECT: begin
                if (r_remaining == 4'd0) begin
                    w_next_state = DONE;
                end else if (w_pick != 4'd0) begin
                    w_next_eject_sel = w_pick;
                    w_next_state     = EJECT;
                end else begin
                    // Flag is raised on entry so it coincides with done
                    w_next_short_fault = 1'b1;
                    w_next_state       = FAULT;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    w_dec_en         = 1'b1;
                    w_next_remaining = r_remaining - coin_value(r_eject_sel);
                    w_next_state     = SELECT;
                end else if (w_timeout) begin
                    w_next_short_fault = 1'b1;
                    w_next_state       = FAULT;
                end
            end
            DONE:    w_next_state = IDLE;
            FAULT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign change_ready = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign eject_req    = (r_state == EJECT);
    assign eject_sel    = (r_state == EJECT) ? r_eject_sel : 4'd0;
    assign done         = (r_state == DONE) || (r_state == FAULT);
    assign short_fault  = r_short_fault;
    assign remaining    = r_remaining;
    assign tube_count   = w_counts;

endmodule
`default_nettype wire

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port change_valid, input, 1, change request present.
REQ-004 SHALL have port change_amount, input, 4, change owed in units (0..15); sampled on accept.
REQ-005 SHALL have port change_ready, output, 1, high only in IDLE.
REQ-006 SHALL have port eject_req, output, 1, coin ejector request.
REQ-007 SHALL have port eject_sel, output, 4, one-hot coin: 0001=1, 0010=2, 0100=5, 1000=10; 0 when eject_req low.
REQ-008 SHALL have port eject_ack, input, 1, ejector accepted one coin.
REQ-009 SHALL have port refill, input, 1, add one coin to the tube selected by refill_sel.
REQ-010 SHALL have port refill_sel, input, 4, one-hot tube select for refill; non-one-hot is ignored.
REQ-011 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on completion.
REQ-013 SHALL have port short_fault, output, 1, sticky: change could not be fully paid.
REQ-014 SHALL have port remaining, output, 4, units still owed.
REQ-015 SHALL have port tube_count, output, 16, four 4-bit counts: [3:0]=1, [7:4]=2, [11:8]=5, [15:12]=10.

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, EJECT, DONE, FAULT.
REQ-017 IDLE: on change_valid=1, SHALL load remaining<=change_amount, clear short_fault, and go to SELECT next cycle.
REQ-018 SELECT: remaining=0 SHALL go to DONE; else SHALL pick the largest denomination <= remaining whose tube count is >0, register eject_sel, and go to EJECT.
REQ-019 SELECT with remaining>0 and no eligible denomination SHALL go to FAULT.
REQ-020 EJECT: eject_req SHALL stay high with eject_sel stable until a cycle with eject_ack=1.
REQ-021 On that ack cycle, remaining SHALL decrease by the coin value, the tube count SHALL decrement, eject_req SHALL drop, and the FSM SHALL return to SELECT; each coin takes at least 2 cycles.
REQ-022 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-023 FAULT SHALL set short_fault=1, keep remaining at the unpaid amount, pulse done for one cycle, and return to IDLE.
REQ-024 change_amount=0 SHALL produce done exactly 2 cycles after accept with no ejection.
REQ-025 eject_ack outside EJECT SHALL be ignored.
REQ-026 Refill SHALL increment a tube count and saturate at 15; it SHALL be accepted in any state.
REQ-027 Refill and ack-decrement on the same tube in the same cycle SHALL leave the count unchanged.
REQ-028 Greedy selection SHALL use counts registered as of the SELECT cycle.

Reset
REQ-029 Reset SHALL override all activity in any state, including mid-EJECT, and SHALL force next state IDLE.
REQ-030 Reset SHALL clear eject_req, eject_sel, busy, done, short_fault, and remaining.
REQ-031 Reset SHALL set every tube count to 4'd5; change_ready SHALL be 1 the cycle after reset releases.

Configuration
REQ-032 With CHANGE_ACK_TIMEOUT_EN defined, an 8-bit counter SHALL run in EJECT; after 255 cycles without ack the FSM SHALL drop eject_req and go to FAULT, leaving the tube unchanged.
REQ-033 Without CHANGE_ACK_TIMEOUT_EN, EJECT SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-034 Package vm_pkg SHALL hold the FSM state enum, the one-hot coin constants (COIN_1/2/5/10), their unit values, and TUBE_RESET=5.
REQ-035 The four saturating tube counters, with refill/decrement arbitration, SHALL live in sub-module cd_tube_bank; the FSM and greedy picker stay in the top.

Verification
REQ-036 amount=13, all tubes=5, ack returned 1 cycle after each req -> coins 10,2,1; done; remaining=0; counts 10:4, 2:4, 1:4.
REQ-037 amount=10, tube 10=0 -> coins 5,5; tube 5=3.
REQ-038 amount=4, tube 2=0, tube 1=1 -> one 1-coin ejected, then FAULT: short_fault=1, remaining=3, done pulse.
REQ-039 Reset asserted while eject_req=1 -> next cycle IDLE, eject_req=0, counts all 5; refill on a count of 15 -> stays 15.
REQ-040 CHANGE_ACK_TIMEOUT_EN defined, ack never given -> eject_req drops after 255 cycles; short_fault=1; remaining unchanged.
